// File: rtl/uint16_number_entry_if.sv
// Keypad-side and downstream-side signals of the UInt16 number entry block.
// master drives keys and out_ready; slave is the entry block itself.
interface uint16_number_entry_if;
    logic [9:0]  digit_keys;
    logic        clear;
    logic        enter;
    logic        out_ready;
    logic [15:0] value;
    logic [2:0]  digit_count;
    logic [15:0] number_out;
    logic        out_valid;
    logic        invalid_input;
    logic        overflow;

    modport master (
        output digit_keys, clear, enter, out_ready,
        input  value, digit_count, number_out, out_valid, invalid_input, overflow
    );

    modport slave (
        input  digit_keys, clear, enter, out_ready,
        output value, digit_count, number_out, out_valid, invalid_input, overflow
    );
endinterface

// File: rtl/uint16_number_entry.sv
// Keypad front end accumulating a decimal UInt16 (value*10 + digit) on key-press edges.
// Events act at the detecting edge; a committed number is held on out_valid until out_ready.
module uint16_number_entry #(
    parameter int unsigned MAX_VALUE = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uint16_number_entry_if.slave bus
);
    localparam logic [1:0] ST_ENTRY  = 2'd0;
    localparam logic [1:0] ST_OUTPUT = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    logic [1:0]  r_state;
    logic [9:0]  r_keys_prev;
    logic        r_clear_prev;
    logic        r_enter_prev;
    logic [15:0] r_value;
    logic [2:0]  r_digit_count;
    logic        r_entered;
    logic [15:0] r_number_out;
    logic        r_out_valid;
    logic        r_invalid;

    logic        w_digit_ev;
    logic        w_enter_ev;
    logic        w_clear_ev;
    logic        w_onehot;
    logic [3:0]  w_digit;
    logic [19:0] w_accum;
    logic        w_too_big;

    assign w_digit_ev = (|bus.digit_keys) & ~(|r_keys_prev);
    assign w_enter_ev = bus.enter & ~r_enter_prev;
    assign w_clear_ev = bus.clear & ~r_clear_prev;
    assign w_onehot   = (bus.digit_keys != 10'd0) &&
                        ((bus.digit_keys & (bus.digit_keys - 10'd1)) == 10'd0);

    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.digit_keys[i]) w_digit = 4'(i);
        end
    end

    // 20 bits holds 65535*10+9 without wrapping, so the limit compare is exact.
    assign w_accum   = {4'd0, r_value} * 20'd10 + {16'd0, w_digit};
    assign w_too_big = w_accum > 20'(MAX_VALUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ENTRY;
            r_keys_prev   <= 10'd0;
            r_clear_prev  <= 1'b0;
            r_enter_prev  <= 1'b0;
            r_value       <= 16'd0;
            r_digit_count <= 3'd0;
            r_entered     <= 1'b0;
            r_number_out  <= 16'd0;
            r_out_valid   <= 1'b0;
            r_invalid     <= 1'b0;
        end else begin
            r_keys_prev  <= bus.digit_keys;
            r_clear_prev <= bus.clear;
            r_enter_prev <= bus.enter;
            r_invalid    <= 1'b0;
            if (w_clear_ev) begin
                r_state       <= ST_ENTRY;
                r_value       <= 16'd0;
                r_digit_count <= 3'd0;
                r_entered     <= 1'b0;
                r_out_valid   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ENTRY: begin
                        if (w_enter_ev) begin
                            if (r_entered) begin
                                r_number_out <= r_value;
                                r_out_valid  <= 1'b1;
                                r_state      <= ST_OUTPUT;
                            end else begin
                                r_invalid <= 1'b1;
                            end
                        end else if (w_digit_ev) begin
                            if (!w_onehot) begin
                                r_invalid <= 1'b1;
                            end else if (w_too_big) begin
                                r_state <= ST_ERROR;
                            end else begin
                                r_value   <= w_accum[15:0];
                                r_entered <= 1'b1;
                                // Leading zeros are accepted but are not significant digits.
                                if (!(r_value == 16'd0 && w_digit == 4'd0) && r_digit_count != 3'd5)
                                    r_digit_count <= r_digit_count + 3'd1;
                            end
                        end
                    end
                    ST_OUTPUT: begin
                        if (r_out_valid && bus.out_ready) begin
                            r_out_valid   <= 1'b0;
                            r_value       <= 16'd0;
                            r_digit_count <= 3'd0;
                            r_entered     <= 1'b0;
                            r_state       <= ST_ENTRY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.value         = r_value;
    assign bus.digit_count   = r_digit_count;
    assign bus.number_out    = r_number_out;
    assign bus.out_valid     = r_out_valid;
    assign bus.invalid_input = r_invalid;
    assign bus.overflow      = (r_state == ST_ERROR);
endmodule

// File: tb/tb_uint16_number_entry.sv
// Bench for uint16_number_entry: two instances (full range and MAX_VALUE=999) share one stimulus
// stream and are compared every cycle against a behavioural model, plus directed scenario checks.
module tb_uint16_number_entry;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] keys = '0;
    logic clr = 1'b0, ent = 1'b0, rdy = 1'b0;

    uint16_number_entry_if ifa ();
    uint16_number_entry_if ifb ();

    assign ifa.digit_keys = keys;
    assign ifa.clear      = clr;
    assign ifa.enter      = ent;
    assign ifa.out_ready  = rdy;
    assign ifb.digit_keys = keys;
    assign ifb.clear      = clr;
    assign ifb.enter      = ent;
    assign ifb.out_ready  = rdy;

    uint16_number_entry #(.MAX_VALUE(65535)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    uint16_number_entry #(.MAX_VALUE(999))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct packed {
        logic [15:0] value;
        logic [2:0]  cnt;
        logic [15:0] num;
        logic        vld;
        logic        inv;
        logic        ovf;
        logic        entered;
        logic [9:0]  kp;
        logic        cp;
        logic        ep;
    } mdl_t;

    mdl_t m_a, m_b;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock of keypad behaviour, written from the user-visible rules.
    function automatic mdl_t step(mdl_t m, int maxv, logic [9:0] k, logic c, logic e, logic r);
        mdl_t n = m;
        bit dig_ev = (k != 0) && (m.kp == 0);
        bit ent_ev = e && !m.ep;
        bit clr_ev = c && !m.cp;
        int d, nv;
        n.kp = k; n.cp = c; n.ep = e; n.inv = 1'b0;
        if (clr_ev) begin
            n.value = 0; n.cnt = 0; n.entered = 0; n.ovf = 0; n.vld = 0;
        end else if (m.vld) begin
            if (r) begin n.vld = 0; n.value = 0; n.cnt = 0; n.entered = 0; end
        end else if (m.ovf) begin
            n.ovf = 1'b1;
        end else if (ent_ev) begin
            if (m.entered) begin n.num = m.value; n.vld = 1'b1; end
            else n.inv = 1'b1;
        end else if (dig_ev) begin
            if ($countones(k) != 1) n.inv = 1'b1;
            else begin
                d = $clog2(k);
                nv = int'(m.value) * 10 + d;
                if (nv > maxv) n.ovf = 1'b1;
                else begin
                    n.value = 16'(nv);
                    n.entered = 1'b1;
                    if (!(m.value == 0 && d == 0) && m.cnt < 5) n.cnt = m.cnt + 3'd1;
                end
            end
        end
        return n;
    endfunction

    task automatic check_both();
        chk("a_value", ifa.value, m_a.value);
        chk("a_count", ifa.digit_count, m_a.cnt);
        chk("a_number", ifa.number_out, m_a.num);
        chk("a_valid", ifa.out_valid, m_a.vld);
        chk("a_invalid", ifa.invalid_input, m_a.inv);
        chk("a_overflow", ifa.overflow, m_a.ovf);
        chk("b_value", ifb.value, m_b.value);
        chk("b_count", ifb.digit_count, m_b.cnt);
        chk("b_number", ifb.number_out, m_b.num);
        chk("b_valid", ifb.out_valid, m_b.vld);
        chk("b_invalid", ifb.invalid_input, m_b.inv);
        chk("b_overflow", ifb.overflow, m_b.ovf);
    endtask

    task automatic cyc(input logic [9:0] k, input logic c, input logic e, input logic r);
        keys = k; clr = c; ent = e; rdy = r;
        @(posedge clk);
        m_a = step(m_a, 65535, k, c, e, r);
        m_b = step(m_b, 999, k, c, e, r);
        #1;
        check_both();
    endtask

    task automatic press(input int d, input logic r);
        logic [9:0] k;
        k = 10'd1 << d;
        cyc(k, 1'b0, 1'b0, r);
        cyc(10'd0, 1'b0, 1'b0, r);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_a = '0;
        m_b = '0;
        check_both();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_a = '0;
        m_b = '0;
        @(posedge clk);
        #1;
        check_both();
        @(negedge clk);
        rst_n = 1'b1;

        // 4, 2, 7 then enter with downstream ready
        press(4, 1'b1); chk("tp1_val4", ifa.value, 4);
        press(2, 1'b1); chk("tp1_val42", ifa.value, 42);
        press(7, 1'b1); chk("tp1_val427", ifa.value, 427);
        chk("tp1_cnt3", ifa.digit_count, 3);
        cyc(10'd0, 1'b0, 1'b1, 1'b1);
        chk("tp1_vld", ifa.out_valid, 1);
        chk("tp1_num", ifa.number_out, 427);
        cyc(10'd0, 1'b0, 1'b0, 1'b1);
        chk("tp1_vld_drop", ifa.out_valid, 0);
        chk("tp1_val0", ifa.value, 0);

        // full range and overflow
        press(6, 1'b0); press(5, 1'b0); press(5, 1'b0); press(3, 1'b0); press(5, 1'b0);
        chk("tp2_max", ifa.value, 65535);
        chk("tp2_cnt5", ifa.digit_count, 5);
        press(0, 1'b0);
        chk("tp2_ovf", ifa.overflow, 1);
        chk("tp2_hold", ifa.value, 65535);
        press(1, 1'b0);
        cyc(10'd0, 1'b0, 1'b1, 1'b1);
        chk("tp2_ign_ent", ifa.out_valid, 0);
        cyc(10'd0, 1'b0, 1'b0, 1'b1);
        cyc(10'd0, 1'b1, 1'b0, 1'b0);
        chk("tp2_clr_ovf", ifa.overflow, 0);
        chk("tp2_clr_val", ifa.value, 0);
        cyc(10'd0, 1'b1, 1'b0, 1'b0);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);

        // multi-key rejection and held-key no-repeat
        cyc(10'b0000100100, 1'b0, 1'b0, 1'b0);
        chk("tp3_inv", ifa.invalid_input, 1);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        chk("tp3_inv_pulse", ifa.invalid_input, 0);
        chk("tp3_val", ifa.value, 0);
        for (int i = 0; i < 8; i++) cyc(10'b0000001000, 1'b0, 1'b0, 1'b0);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        chk("tp3_once", ifa.value, 3);

        // enter with nothing entered, then a lone zero
        do_reset();
        cyc(10'd0, 1'b0, 1'b1, 1'b0);
        chk("tp4_inv", ifa.invalid_input, 1);
        chk("tp4_novld", ifa.out_valid, 0);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        press(0, 1'b0);
        cyc(10'd0, 1'b0, 1'b1, 1'b0);
        chk("tp4_vld", ifa.out_valid, 1);
        chk("tp4_num", ifa.number_out, 0);
        chk("tp4_cnt", ifa.digit_count, 0);
        cyc(10'd0, 1'b0, 1'b0, 1'b1);

        // backpressure, then clear dropping a pending output
        press(1, 1'b0); press(2, 1'b0); press(3, 1'b0);
        cyc(10'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc((i % 2) ? 10'd0 : 10'b0010000000, 1'b0, 1'b0, 1'b0);
            chk("tp5_hold_vld", ifa.out_valid, 1);
            chk("tp5_hold_num", ifa.number_out, 123);
        end
        cyc(10'd0, 1'b0, 1'b0, 1'b1);
        chk("tp5_xfer", ifa.out_valid, 0);
        press(1, 1'b0); press(2, 1'b0); press(3, 1'b0);
        cyc(10'd0, 1'b0, 1'b1, 1'b0);
        cyc(10'd0, 1'b1, 1'b0, 1'b0);
        chk("tp5_clr_drop", ifa.out_valid, 0);
        cyc(10'd0, 1'b0, 1'b0, 1'b1);
        chk("tp5_no_deliver", ifa.out_valid, 0);

        // small limit instance, and reset mid-entry / while pending
        press(9, 1'b0); press(9, 1'b0); press(9, 1'b0);
        chk("tp6_b999", ifb.value, 999);
        press(1, 1'b0);
        chk("tp6_b_ovf", ifb.overflow, 1);
        cyc(10'd0, 1'b1, 1'b0, 1'b0);
        cyc(10'd0, 1'b0, 1'b0, 1'b0);
        press(1, 1'b1); press(2, 1'b1);
        do_reset();
        chk("tp6_rst_val", ifa.value, 0);
        press(5, 1'b0);
        cyc(10'd0, 1'b0, 1'b1, 1'b1);
        rdy = 1'b1;
        do_reset();
        chk("tp6_rst_vld", ifa.out_valid, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [9:0] k;
            sel = $urandom_range(99);
            if (sel < 50) k = 10'd0;
            else if (sel < 88) k = 10'd1 << $urandom_range(9);
            else k = 10'($urandom);
            cyc(k, ($urandom_range(99) < 3), ($urandom_range(99) < 10), ($urandom_range(1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
